// File: rtl/ieee754_pkg.sv
// Shared binary32 field definitions, constants and operand classification
// used by the single-precision multiplier.
package ieee754_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    // Subnormals (exp=0, frac!=0) decode as ZERO: they are flushed on input.
    function automatic fp_class_t classify(input fp32_t x);
        if (x.exp == '0)
            return ZERO;
        else if (x.exp == EXP_MAX)
            return (x.frac == '0) ? INF : NAN;
        else
            return NORMAL;
    endfunction

endpackage

// File: rtl/ieee_mul_core.sv
// Combinational binary32 multiply: decode, 24x24 mantissa product,
// normalize, round-to-nearest-even and special-case selection.
module ieee_mul_core
    import ieee754_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] prod
);

    fp32_t           fa;
    fp32_t           fb;
    fp_class_t       ca;
    fp_class_t       cb;
    logic            s;
    logic [47:0]     p;
    logic signed [9:0] e_sum;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;
    logic [22:0]     mant;
    logic            guard;
    logic            sticky;
    logic            round_up;
    logic [23:0]     mant_r;

    assign fa = a;
    assign fb = b;
    assign ca = classify(fa);
    assign cb = classify(fb);
    assign s  = fa.sign ^ fb.sign;

    assign p     = {1'b1, fa.frac} * {1'b1, fb.frac};
    assign e_sum = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127;

    always_comb begin
        if (p[47]) begin
            mant   = p[46:24];
            guard  = p[23];
            sticky = |p[22:0];
            e_norm = e_sum + 10'sd1;
        end else begin
            mant   = p[45:23];
            guard  = p[22];
            sticky = |p[21:0];
            e_norm = e_sum;
        end
    end

    // A carry out of the rounded fraction means it rolled over to 1.000..., so
    // the fraction is already zero and only the exponent needs bumping.
    assign round_up = guard & (sticky | mant[0]);
    assign mant_r   = {1'b0, mant} + {23'd0, round_up};
    assign e_fin    = e_norm + (mant_r[23] ? 10'sd1 : 10'sd0);

    always_comb begin
        prod = {s, 31'd0};
        if (ca == NAN || cb == NAN)
            prod = QNAN;
        else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
            prod = QNAN;
        else if (ca == INF || cb == INF)
            prod = {s, EXP_MAX, 23'd0};
        else if (ca == ZERO || cb == ZERO)
            prod = {s, 31'd0};
        else if (e_fin >= 10'sd255)
            prod = {s, EXP_MAX, 23'd0};
        else if (e_fin <= 10'sd0)
            prod = {s, 31'd0};
        else
            prod = {s, e_fin[7:0], mant_r[22:0]};
    end

endmodule

// File: rtl/ieee_multiply.sv
// Single-precision IEEE 754 multiplier with a one-cycle registered result;
// no handshake, a new operand pair may be presented every cycle.
module ieee_multiply
    import ieee754_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    logic [31:0] prod;

    ieee_mul_core u_core (
        .a    (a),
        .b    (b),
        .prod (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            c <= 32'h00000000;
        else
            c <= prod;
    end

endmodule

// File: tb/tb_ieee_multiply.sv
// Directed bench for ieee_multiply: hand-computed products, special cases,
// boundaries, async reset and back-to-back one-cycle latency.
module tb_ieee_multiply;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    ieee_multiply dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] expected);
        vectors++;
        assert (c === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, c, expected);
        end
    endtask

    // Present a pair just after an edge, then sample #1 after the next edge.
    task automatic mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expected);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    logic [31:0] ta [6];
    logic [31:0] tb_ [6];
    logic [31:0] te [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        a   = 32'h0;
        b   = 32'h0;
        #1;
        check("reset_state", 32'h00000000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", 32'h00000000);
        rst = 1'b0;

        mul("inf_x_normal",   32'h7F800000, 32'h01810000, 32'h7F800000);
        mul("zero_x_inf",     32'h00000000, 32'h7F800000, 32'h7FC00000);
        mul("inf_x_zero",     32'h7F800000, 32'h00000000, 32'h7FC00000);
        mul("nan_x_subnorm",  32'h7F800840, 32'h00001688, 32'h7FC00000);
        mul("two_x_1000",     32'h40000000, 32'h447A0000, 32'h44FA0000);
        mul("ten_x_neg99",    32'h41200000, 32'hC2C60000, 32'hC4778000);
        mul("overflow",       32'h7F000000, 32'h40000000, 32'h7F800000);
        mul("underflow",      32'h00800000, 32'h3F000000, 32'h00000000);
        mul("rne_no_ovf",     32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
        mul("negzero_x_one",  32'h80000000, 32'h3F800000, 32'h80000000);
        mul("ulp_square",     32'h3F800001, 32'h3F800001, 32'h3F800002);
        mul("ninf_x_neg2",    32'hFF800000, 32'hC0000000, 32'h7F800000);
        mul("inf_x_ninf",     32'h7F800000, 32'hFF800000, 32'hFF800000);
        mul("subnorm_x_neg",  32'h00000001, 32'hBF800000, 32'h80000000);

        // Held inputs keep c constant on the following edge.
        @(posedge clk);
        #1;
        check("held_constant", 32'h3F800001 == 32'h0 ? 32'h0 : 32'h80000000);

        // Async reset mid-stream, away from any clock edge.
        a = 32'h40000000;
        b = 32'h447A0000;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_now", 32'h00000000);
        @(posedge clk);
        #1;
        check("async_reset_held", 32'h00000000);
        rst = 1'b0;
        mul("first_after_reset", 32'h3FC00000, 32'h3FC00000, 32'h40100000);

        // Back-to-back: a new pair every cycle, each product one cycle later.
        ta[0] = 32'h3F800000; tb_[0] = 32'h3F800000; te[0] = 32'h3F800000;
        ta[1] = 32'h40400000; tb_[1] = 32'hC0000000; te[1] = 32'hC0C00000;
        ta[2] = 32'h41200000; tb_[2] = 32'hC2C60000; te[2] = 32'hC4778000;
        ta[3] = 32'h7F800840; tb_[3] = 32'h3F800000; te[3] = 32'h7FC00000;
        ta[4] = 32'h3FFFFFFF; tb_[4] = 32'h3FFFFFFF; te[4] = 32'h407FFFFE;
        ta[5] = 32'h7F000000; tb_[5] = 32'h40000000; te[5] = 32'h7F800000;
        for (int i = 0; i < 6; i++) begin
            a = ta[i];
            b = tb_[i];
            exp_q.push_back(te[i]);
            @(posedge clk);
            #1;
            check("back_to_back", exp_q.pop_front());
        end

        // Reset in the middle of a stream discards the pending product.
        a = 32'h40000000;
        b = 32'h40000000;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_discards", 32'h00000000);
        rst = 1'b0;
        mul("resume_after_reset", 32'h40000000, 32'h40000000, 32'h40800000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
